// File: rtl/polar_pkg.sv
// Shared polar-sample layout, matching the cartesian_to_polar output stream.
package polar_pkg;

  localparam int MAG_WIDTH   = 32;
  localparam int PHASE_WIDTH = 32;
  localparam logic [PHASE_WIDTH-1:0] PHASE_PI = 32'h8000_0000;

  typedef struct packed {
    logic        [MAG_WIDTH-1:0]   magnitude;
    logic signed [PHASE_WIDTH-1:0] phase;
  } polar_t;

endpackage

// File: rtl/frequency_offset_estimator.sv
// Averages wrapped phase steps over windows of 2^LOG2_LEN deltas (CFO estimate).
// Define FREQUENCY_OFFSET_ESTIMATOR_MAG_GATE_EN to drop deltas touching weak samples.
module frequency_offset_estimator
  import polar_pkg::*;
#(
  parameter int          LOG2_LEN      = 4,
  parameter logic [31:0] MAG_THRESHOLD = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_data
);

  localparam int ACC_W = PHASE_WIDTH + LOG2_LEN;
  localparam logic [1:0] ST_FIRST  = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_OUTPUT = 2'd2;

  polar_t sample;
  assign sample = s_data;

  logic [1:0]                state;
  logic signed [ACC_W-1:0]   acc;
  logic [LOG2_LEN-1:0]       win_cnt;
  logic [PHASE_WIDTH-1:0]    prev_phase;

  logic                      s_accept;
  logic                      m_accept;
  logic [PHASE_WIDTH-1:0]    delta;
  logic                      contrib;
  logic [LOG2_LEN:0]         count_final;
  logic signed [ACC_W-1:0]   acc_final;
  logic signed [ACC_W-1:0]   avg_full;
  logic                      last_delta;

  assign s_accept   = s_valid && s_ready;
  assign m_accept   = m_valid && m_ready;
  // Modulo-2^32 difference gives the natural +/-pi wrap for free.
  assign delta      = sample.phase - prev_phase;
  assign last_delta = (win_cnt == {LOG2_LEN{1'b1}});

`ifdef FREQUENCY_OFFSET_ESTIMATOR_MAG_GATE_EN
  logic              prev_ok;
  logic              cur_ok;
  logic [LOG2_LEN:0] ok_cnt;

  assign cur_ok      = (sample.magnitude >= MAG_THRESHOLD);
  assign contrib     = prev_ok && cur_ok;
  assign count_final = ok_cnt + {{LOG2_LEN{1'b0}}, contrib};
`else
  logic unused_mag;

  assign unused_mag  = ^{sample.magnitude, MAG_THRESHOLD};
  assign contrib     = 1'b1;
  assign count_final = (LOG2_LEN + 1)'(1) << LOG2_LEN;
`endif

  assign acc_final = acc + (contrib ? {{LOG2_LEN{delta[PHASE_WIDTH-1]}}, delta} : '0);
  assign avg_full  = acc_final >>> LOG2_LEN;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_FIRST;
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      acc        <= '0;
      win_cnt    <= '0;
      prev_phase <= '0;
`ifdef FREQUENCY_OFFSET_ESTIMATOR_MAG_GATE_EN
      prev_ok    <= 1'b0;
      ok_cnt     <= '0;
`endif
    end else begin
      case (state)
        ST_FIRST: begin
          s_ready <= 1'b1;
          if (s_accept) begin
            prev_phase <= sample.phase;
            acc        <= '0;
            win_cnt    <= '0;
`ifdef FREQUENCY_OFFSET_ESTIMATOR_MAG_GATE_EN
            prev_ok    <= cur_ok;
            ok_cnt     <= '0;
`endif
            state      <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (s_accept) begin
            acc        <= acc_final;
            prev_phase <= sample.phase;
            win_cnt    <= win_cnt + 1'b1;
`ifdef FREQUENCY_OFFSET_ESTIMATOR_MAG_GATE_EN
            prev_ok    <= cur_ok;
            ok_cnt     <= count_final;
`endif
            if (last_delta) begin
              m_data  <= {32'(count_final), avg_full[PHASE_WIDTH-1:0]};
              m_valid <= 1'b1;
              s_ready <= 1'b0;
              state   <= ST_OUTPUT;
            end
          end
        end
        ST_OUTPUT: begin
          if (m_accept) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            acc     <= '0;
            win_cnt <= '0;
`ifdef FREQUENCY_OFFSET_ESTIMATOR_MAG_GATE_EN
            ok_cnt  <= '0;
`endif
            state   <= ST_ACCUM;
          end
        end
        default: begin
          state   <= ST_FIRST;
          s_ready <= 1'b0;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frequency_offset_estimator.sv
// Bench for frequency_offset_estimator: directed vectors plus a window-level reference model.
module tb_frequency_offset_estimator;

`ifdef FREQUENCY_OFFSET_ESTIMATOR_MAG_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data = '0;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic        m_ready_dir = 1'b1;
  logic        rand_mode = 1'b0;
  logic        rand_rdy = 1'b1;

  int errors = 0;
  int checks = 0;

  frequency_offset_estimator dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
  );

  always #5 clk = ~clk;
  assign m_ready = rand_mode ? rand_rdy : m_ready_dir;

  initial forever begin
    @(posedge clk);
    #1 rand_rdy = 1'($urandom_range(1));
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: history of accepted samples since reset.
  logic [31:0] ph_q[$];
  logic [31:0] mg_q[$];
  int consumed = 0;
  int since_rst = 0;

  function automatic logic [63:0] model_window(input int w);
    logic signed [63:0] sum;
    logic signed [63:0] avg;
    logic [31:0] cnt;
    logic [31:0] d;
    int n;
    bit ok;
    sum = '0;
    cnt = '0;
    for (int k = 1; k <= 16; k++) begin
      n  = w * 16 + k;
      d  = ph_q[n] - ph_q[n-1];
      ok = !GATE || (mg_q[n] >= 32'h100 && mg_q[n-1] >= 32'h100);
      if (ok) begin
        sum = sum + {{32{d[31]}}, d};
        cnt = cnt + 1;
      end
    end
    avg = sum >>> 4;
    return {cnt, avg[31:0]};
  endfunction

  always @(negedge clk or posedge reset) begin
    int done;
    bit exp_valid;
    if (reset) begin
      ph_q.delete();
      mg_q.delete();
      consumed  = 0;
      since_rst = 0;
      if (!clk) begin
        check("reset_m_valid", {63'd0, m_valid}, 64'd0);
        check("reset_s_ready", {63'd0, s_ready}, 64'd0);
        check("reset_m_data", m_data, 64'd0);
      end
    end else begin
      done = (ph_q.size() >= 17) ? (ph_q.size() - 1) / 16 : 0;
      exp_valid = (done > consumed);
      check("m_valid", {63'd0, m_valid}, {63'd0, exp_valid});
      if (exp_valid) check("m_data", m_data, model_window(consumed));
      if (since_rst > 0) check("s_ready", {63'd0, s_ready}, {63'd0, !exp_valid});
      if (m_valid && m_ready) consumed++;
      if (s_valid && s_ready) begin
        ph_q.push_back(s_data[31:0]);
        mg_q.push_back(s_data[63:32]);
      end
      since_rst++;
    end
  end

  task automatic send(input logic [31:0] mag, input logic [31:0] ph, input bit gaps);
    int waitc;
    bit took;
    waitc = 0;
    took  = 1'b0;
    if (gaps) begin
      while ($urandom_range(1) == 1) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    s_valid = 1'b1;
    s_data  = {mag, ph};
    while (!took) begin
      @(negedge clk);
      took = s_ready;
      @(posedge clk);
      #1;
      waitc++;
      if (!took && waitc > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got no s_ready expected accept within 200 cycles");
        took = 1'b1;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic get_out(output logic [63:0] d);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_valid && n < 100);
    if (!m_valid) begin
      checks++;
      errors++;
      $display("FAIL out_timeout: got m_valid=0 expected 1 within 100 cycles");
    end
    d = m_data;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("pulse_m_valid", {63'd0, m_valid}, 64'd0);
    check("pulse_s_ready", {63'd0, s_ready}, 64'd0);
    check("pulse_m_data", m_data, 64'd0);
    #1 reset = 1'b0;
  endtask

  task automatic ramp(input int first, input int count, input logic [31:0] start, input logic [31:0] step);
    for (int i = first; i < first + count; i++)
      send(32'h4000, start + step * 32'(i), 1'b0);
  endtask

  logic [63:0] d1;
  logic [63:0] d2;
  int bound;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    ramp(0, 17, 32'h0, 32'h0800_0000);
    get_out(d1);
    check("ramp", d1, {32'd16, 32'h0800_0000});

    pulse_reset();
    ramp(0, 17, 32'h7000_0000, 32'h2000_0000);
    get_out(d1);
    check("wrap_pos", d1, {32'd16, 32'h2000_0000});

    pulse_reset();
    ramp(0, 17, 32'h8800_0000, 32'hFF00_0000);
    get_out(d1);
    check("wrap_neg", d1, {32'd16, 32'hFF00_0000});

    pulse_reset();
    for (int i = 0; i < 17; i++)
      send((i == 5) ? 32'h0 : 32'h4000, 32'h0800_0000 * 32'(i), 1'b0);
    get_out(d1);
    check("gating", d1, GATE ? {32'd14, 32'h0700_0000} : {32'd16, 32'h0800_0000});

    pulse_reset();
    m_ready_dir = 1'b0;
    ramp(0, 17, 32'h0, 32'h0800_0000);
    bound = 0;
    do begin
      @(negedge clk);
      bound++;
    end while (!m_valid && bound < 50);
    d1 = m_data;
    check("bp_first", d1, {32'd16, 32'h0800_0000});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_s_ready", {63'd0, s_ready}, 64'd0);
      check("bp_hold", m_data, {32'd16, 32'h0800_0000});
    end
    @(posedge clk);
    #1 m_ready_dir = 1'b1;
    ramp(17, 16, 32'h0, 32'h0800_0000);
    get_out(d2);
    check("bp_second", d2, {32'd16, 32'h0800_0000});

    pulse_reset();
    for (int i = 0; i < 8; i++) send(32'h4000, $urandom, 1'b0);
    pulse_reset();
    ramp(0, 17, 32'h0, 32'h0800_0000);
    get_out(d1);
    check("after_reset", d1, {32'd16, 32'h0800_0000});

    pulse_reset();
    rand_mode = 1'b1;
    for (int i = 0; i < 81; i++)
      send(($urandom_range(4) == 0) ? 32'($urandom_range(255)) : 32'h4000 + 32'($urandom_range(65535)),
           $urandom, 1'b1);
    bound = 0;
    while (consumed < 5 && bound < 500) begin
      @(posedge clk);
      bound++;
    end
    check("random_windows", 64'(consumed), 64'd5);
    rand_mode = 1'b0;

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
